level_seq_loader: RTL and testbench
===================================

LEVEL_SEQ_LOADER -- requirements
Module: level_seq_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of sequence entries loaded, minimum 2.
REQ-002 SHALL have parameter COLOR_W, default 2: width of one colour entry.
REQ-003 SHALL have parameter ROM_LAT, default 1: source ROM read latency in cycles, minimum 1.
REQ-004 SHALL derive local ADDR_W = clog2(DEPTH); it is not a port-settable parameter.
REQ-005 SHALL have clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have start, input, 1: load request, sampled in IDLE only.
REQ-008 SHALL have mode, input, 1: 0 = copy from ROM, 1 = pseudo-random fill; sampled with start.
REQ-009 SHALL have seed, input, 16: LFSR seed, sampled with start.
REQ-010 SHALL have rom_addr, output, ADDR_W: ROM read address.
REQ-011 SHALL have rom_data, input, COLOR_W: ROM read data, valid ROM_LAT cycles after rom_addr.
REQ-012 SHALL have mem_addr, output, ADDR_W: sequence-memory write address.
REQ-013 SHALL have mem_data, output, COLOR_W: sequence-memory write data.
REQ-014 SHALL have mem_we, output, 1: write strobe, exactly one cycle per entry.
REQ-015 SHALL have busy, output, 1: high in FETCH and WRITE.
REQ-016 SHALL have done, output, 1: one-cycle pulse when all DEPTH entries are written.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, WRITE, DONE; all outputs registered.
REQ-018 IDLE: start=1 latches mode and seed, clears index to 0, and moves to FETCH (mode 0) or WRITE (mode 1).
REQ-019 FETCH: rom_addr = index; wait counter runs ROM_LAT cycles; rom_data is captured on the final FETCH cycle; then WRITE.
REQ-020 WRITE: mem_we=1, mem_addr=index, mem_data = captured ROM word (mode 0) or lfsr[COLOR_W-1:0] (mode 1), for exactly one cycle.
REQ-021 After WRITE: if index == DEPTH-1, go to DONE; otherwise index increments and the FSM returns to FETCH (mode 0) or stays in WRITE (mode 1).
REQ-022 DONE: done=1 for one cycle, then IDLE; mem_we=0.
REQ-023 Throughput SHALL be ROM_LAT+1 cycles per entry in mode 0 and 1 cycle per entry in mode 1.
REQ-024 LFSR SHALL be 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting once per WRITE cycle after the write.
REQ-025 A seed of 0 SHALL be replaced by 16'hACE1 at load.
REQ-026 start while not IDLE SHALL be ignored; mode and seed changes mid-load SHALL have no effect.
REQ-027 The index counter SHALL be ADDR_W bits wide, with no wrap past DEPTH-1; a non-power-of-2 DEPTH SHALL terminate correctly.
REQ-028 rom_addr, mem_addr and mem_data SHALL hold their last values outside active states; mem_we is never high outside WRITE.

Reset
REQ-029 reset=1 SHALL immediately force IDLE and zero index, wait counter, rom_addr, mem_addr, mem_data, mem_we, busy and done; the LFSR resets to 16'hACE1.
REQ-030 reset mid-load SHALL abort without any further mem_we; the next start restarts from index 0.

Structure
REQ-031 State encoding and the default LFSR seed constant SHALL live in a shared package, simon_pkg.
REQ-032 The LFSR SHALL be a separate sub-module, simon_lfsr16, with ports load, seed, step and value.

Verification
REQ-033 Mode 0, DEPTH=8, ROM_LAT=1, ROM = {0,1,2,3,3,2,1,0}, start pulsed: memory receives addresses 0-7 with that data; eight one-cycle mem_we pulses, 2 cycles apart; done is high on cycle 17 after start is sampled.
REQ-034 Mode 0, ROM_LAT=3: pulses are 4 cycles apart; data matches ROM, with no off-by-one address/data skew.
REQ-035 Mode 1, seed=0: written data equals the golden-model LFSR sequence from 16'hACE1; eight consecutive mem_we cycles; done at cycle 9.
REQ-036 reset asserted during the 4th write, then released, then start: no mem_we during reset; a fresh full load of 8 entries from address 0.
REQ-037 start held high throughout a load, with mode toggled mid-load: one load only with the original mode; a second load begins only after IDLE is re-entered.
REQ-038 DEPTH=5: writes to addresses 0-4 only; done follows the write to address 4; addresses 5-7 are never written.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and helpers for the sequence loader.
// Holds the FSM encoding and the LFSR step/seed rules.
package simon_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED_DFLT = 16'hACE1;

  // Right-shifting Fibonacci step, x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] v
  );
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  // An all-zero seed would lock the LFSR.
  function automatic logic [15:0] seed_fix(
    input logic [15:0] s
  );
    return (s == 16'd0) ? LFSR_SEED_DFLT : s;
  endfunction

endpackage

// File: rtl/simon_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load.
// A zero seed is replaced by the default seed.
module simon_lfsr16
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  // Load has priority over step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= LFSR_SEED_DFLT;
    end else if (load) begin
      value <= seed_fix(seed);
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/level_seq_loader.sv
// Loads DEPTH colour entries into sequence memory,
// either copied from ROM or filled from an LFSR.
module level_seq_loader
  import simon_pkg::*;
#(
  parameter  int DEPTH   = 8,
  parameter  int COLOR_W = 2,
  parameter  int ROM_LAT = 1,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [15:0]        seed,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  output logic               busy,
  output logic               done
);

  localparam int WAIT_W =
    (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);
  localparam logic [WAIT_W-1:0] WAIT_END =
    WAIT_W'(ROM_LAT - 1);

  state_t              state;
  logic                mode_q;
  logic [ADDR_W-1:0]   idx;
  logic [WAIT_W-1:0]   wcnt;
  logic [15:0]         lfsr_val;
  logic [15:0]         lfsr_nx;
  logic [15:0]         seed_eff;
  logic                lfsr_load;
  logic                lfsr_step;
  logic                unused_bits;

  assign lfsr_load = (state == S_IDLE) && start;
  assign lfsr_step = (state == S_WRITE);
  assign lfsr_nx   = lfsr_next(lfsr_val);
  assign seed_eff  = seed_fix(seed);

  // Only the low COLOR_W bits reach the memory.
  assign unused_bits = ^{lfsr_nx, seed_eff};

  simon_lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  // Sequencer: outputs are set on entry to each state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      mode_q   <= 1'b0;
      idx      <= '0;
      wcnt     <= '0;
      rom_addr <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            idx    <= '0;
            wcnt   <= '0;
            busy   <= 1'b1;
            if (mode) begin
              state    <= S_WRITE;
              mem_we   <= 1'b1;
              mem_addr <= '0;
              mem_data <= seed_eff[COLOR_W-1:0];
            end else begin
              state    <= S_FETCH;
              rom_addr <= '0;
            end
          end
        end
        S_FETCH: begin
          if (wcnt == WAIT_END) begin
            state    <= S_WRITE;
            mem_we   <= 1'b1;
            mem_addr <= idx;
            mem_data <= rom_data;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (idx == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
            if (mode_q) begin
              mem_we   <= 1'b1;
              mem_addr <= idx + 1'b1;
              mem_data <= lfsr_nx[COLOR_W-1:0];
            end else begin
              state    <= S_FETCH;
              wcnt     <= '0;
              rom_addr <= idx + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_level_seq_loader.sv
// Scoreboard bench for level_seq_loader over three
// parameter sets: (8,LAT1), (8,LAT3), (5,LAT2).
module tb_level_seq_loader;

  localparam int N = 3;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  addr;
    logic [1:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start    [N];
  logic        mode     [N];
  logic [15:0] seed     [N];
  logic [2:0]  rom_addr [N];
  logic [1:0]  rom_data [N];
  logic [2:0]  mem_addr [N];
  logic [1:0]  mem_data [N];
  logic        mem_we   [N];
  logic        busy     [N];
  logic        done     [N];
  logic [1:0]  rom      [N][8];
  logic [1:0]  rpipe    [N][4];

  wr_t wq [N][$];
  int  dq [N][$];
  int  ncmp = 0;
  int  nerr = 0;
  int  cyc  = 0;

  function automatic int dep(input int k);
    return (k == 2) ? 5 : 8;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
  endfunction

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  level_seq_loader #(
    .DEPTH(8), .COLOR_W(2), .ROM_LAT(1)
  ) u_a (
    .clk(clk), .reset(reset),
    .start(start[0]), .mode(mode[0]),
    .seed(seed[0]), .rom_addr(rom_addr[0]),
    .rom_data(rom_data[0]),
    .mem_addr(mem_addr[0]),
    .mem_data(mem_data[0]),
    .mem_we(mem_we[0]), .busy(busy[0]),
    .done(done[0])
  );

  level_seq_loader #(
    .DEPTH(8), .COLOR_W(2), .ROM_LAT(3)
  ) u_b (
    .clk(clk), .reset(reset),
    .start(start[1]), .mode(mode[1]),
    .seed(seed[1]), .rom_addr(rom_addr[1]),
    .rom_data(rom_data[1]),
    .mem_addr(mem_addr[1]),
    .mem_data(mem_data[1]),
    .mem_we(mem_we[1]), .busy(busy[1]),
    .done(done[1])
  );

  level_seq_loader #(
    .DEPTH(5), .COLOR_W(2), .ROM_LAT(2)
  ) u_c (
    .clk(clk), .reset(reset),
    .start(start[2]), .mode(mode[2]),
    .seed(seed[2]), .rom_addr(rom_addr[2]),
    .rom_data(rom_data[2]),
    .mem_addr(mem_addr[2]),
    .mem_data(mem_data[2]),
    .mem_we(mem_we[2]), .busy(busy[2]),
    .done(done[2])
  );

  // ROM with ROM_LAT-1 output registers.
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      rpipe[k][0] <= rom[k][rom_addr[k]];
      for (int j = 1; j < 4; j++)
        rpipe[k][j] <= rpipe[k][j-1];
    end
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      rom_data[k] = rom[k][rom_addr[k]];
      if (lat(k) > 1)
        rom_data[k] = rpipe[k][lat(k)-2];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Expected writes and done time for a load whose
  // start is sampled on edge s.
  task automatic push_load(input int k, input bit m,
                           input logic [15:0] sd,
                           input int s);
    int  l;
    int  b;
    wr_t e;
    l = (sd == 16'd0) ? 32'hACE1 : int'(sd);
    for (int i = 0; i < dep(k); i++) begin
      e.addr = 3'(i);
      if (m) begin
        e.data = 2'(l & 3);
        e.cyc  = 32'(s + i);
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        l = (l >> 1) | (b << 15);
      end else begin
        e.data = rom[k][i];
        e.cyc  = 32'(s + lat(k) + i * (lat(k) + 1));
      end
      wq[k].push_back(e);
    end
    if (m) dq[k].push_back(s + dep(k));
    else   dq[k].push_back(s + dep(k) * (lat(k) + 1));
  endtask

  // Monitor: every strobe must match the head of its queue.
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (mem_we[k] === 1'b1) begin
        if (wq[k].size() == 0) begin
          chk($sformatf("we_unexp%0d", k),
              32'(mem_we[k]), 0);
        end else begin
          wr_t e;
          e = wq[k].pop_front();
          chk($sformatf("addr%0d", k),
              32'(mem_addr[k]), 32'(e.addr));
          chk($sformatf("data%0d", k),
              32'(mem_data[k]), 32'(e.data));
          chk($sformatf("we_cyc%0d", k),
              cyc, e.cyc);
          chk($sformatf("busy%0d", k),
              32'(busy[k]), 1);
        end
      end
      if (done[k] === 1'b1) begin
        if (dq[k].size() == 0) begin
          chk($sformatf("done_unexp%0d", k),
              32'(done[k]), 0);
        end else begin
          chk($sformatf("done_cyc%0d", k),
              cyc, dq[k].pop_front());
        end
      end
    end
  end

  task automatic check_rst(input int k);
    chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 0);
    chk($sformatf("rst_done%0d", k), 32'(done[k]), 0);
    chk($sformatf("rst_we%0d", k), 32'(mem_we[k]), 0);
    chk($sformatf("rst_raddr%0d", k),
        32'(rom_addr[k]), 0);
    chk($sformatf("rst_maddr%0d", k),
        32'(mem_addr[k]), 0);
    chk($sformatf("rst_mdata%0d", k),
        32'(mem_data[k]), 0);
  endtask

  task automatic issue(input int k, input bit m,
                       input logic [15:0] sd,
                       output int s);
    @(negedge clk);
    start[k] = 1'b1;
    mode[k]  = m;
    seed[k]  = sd;
    s = cyc + 1;
    push_load(k, m, sd, s);
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  // Waits for done; optionally disturbs mode/seed meanwhile.
  task automatic wait_done(input int k, input bit scr);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done[k] === 1'b1) begin
        seen = 1'b1;
      end else if (scr) begin
        mode[k] = 1'($urandom);
        seed[k] = 16'($urandom);
      end
    end
    if (!seen) begin
      ncmp++;
      nerr++;
      $display("FAIL timeout%0d: done got 0 expected 1", k);
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s;
    int s1;
    logic [15:0] sd;
    logic [15:0] sd2;
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      start[k] = 1'b0;
      mode[k]  = 1'b0;
      seed[k]  = 16'd0;
      for (int i = 0; i < 8; i++)
        rom[k][i] = 2'($urandom);
    end
    rom[0][0] = 2'd0; rom[0][1] = 2'd1;
    rom[0][2] = 2'd2; rom[0][3] = 2'd3;
    rom[0][4] = 2'd3; rom[0][5] = 2'd2;
    rom[0][6] = 2'd1; rom[0][7] = 2'd0;

    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) check_rst(k);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    issue(0, 1'b0, 16'h1234, s);
    wait_done(0, 1'b1);
    issue(0, 1'b1, 16'h0000, s);
    wait_done(0, 1'b1);
    issue(1, 1'b0, 16'h0000, s);
    wait_done(1, 1'b1);
    issue(2, 1'b0, 16'h0000, s);
    wait_done(2, 1'b1);
    issue(2, 1'b1, 16'hBEEF, s);
    wait_done(2, 1'b1);

    for (int n = 0; n < 16; n++) begin
      int k;
      bit m;
      k  = $urandom_range(0, N - 1);
      m  = 1'($urandom);
      sd = ($urandom_range(0, 3) == 0) ?
           16'd0 : 16'($urandom);
      issue(k, m, sd, s);
      wait_done(k, 1'b1);
    end

    // Reset during the 4th write of a random fill.
    issue(0, 1'b1, 16'($urandom), s);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    wq[0].delete();
    dq[0].delete();
    #1;
    chk("rst_mid_we", 32'(mem_we[0]), 0);
    repeat (3) @(negedge clk);
    check_rst(0);
    reset = 1'b0;
    issue(0, 1'b0, 16'h0000, s);
    wait_done(0, 1'b1);

    // Start held high; mode/seed change mid-load.
    @(negedge clk);
    sd = 16'($urandom);
    start[0] = 1'b1;
    mode[0]  = 1'b0;
    seed[0]  = sd;
    s1 = cyc + 1;
    push_load(0, 1'b0, sd, s1);
    repeat (5) @(negedge clk);
    sd2 = 16'($urandom);
    mode[0] = 1'b1;
    seed[0] = sd2;
    push_load(0, 1'b1, sd2, s1 + 8 * 2 + 2);
    wait_done(0, 1'b0);
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 1'b0);

    repeat (6) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("left_we%0d", k), wq[k].size(), 0);
      chk($sformatf("left_done%0d", k), dq[k].size(), 0);
      chk($sformatf("idle_busy%0d", k), 32'(busy[k]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
